// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX pipeline register bundle presented to the execute stage.
//   master : driven by the ID/EX register (or a testbench)
//   slave  : consumed by ex_stage
// Signals: pc/rs1/rs2/imm data (64b), rs1/rs2/rd indices (5b), decoded
// ALU selectors (func3, func75, op5, ALUop, InstType) and control bits.
interface ex_stage_if;
  logic [63:0] pc_in;
  logic [63:0] rs1_data_in;
  logic [63:0] rs2_data_in;
  logic [63:0] imm_in;
  logic [4:0]  rs1_E_in;
  logic [4:0]  rs2_E_in;
  logic [4:0]  rd_in;
  logic [2:0]  func3_in;
  logic        func75_in;
  logic        op5_in;
  logic [2:0]  ALUop_in;
  logic        InstType_in;
  logic        ALUSrc_in;
  logic        RegWrite_in;
  logic        MemtoReg_in;
  logic        Branch_in;
  logic        Jump_in;
  logic        MemRead_in;
  logic        MemWrite_in;

  modport master (
    output pc_in, rs1_data_in, rs2_data_in, imm_in, rs1_E_in, rs2_E_in, rd_in,
           func3_in, func75_in, op5_in, ALUop_in, InstType_in, ALUSrc_in,
           RegWrite_in, MemtoReg_in, Branch_in, Jump_in, MemRead_in, MemWrite_in
  );

  modport slave (
    input  pc_in, rs1_data_in, rs2_data_in, imm_in, rs1_E_in, rs2_E_in, rd_in,
           func3_in, func75_in, op5_in, ALUop_in, InstType_in, ALUSrc_in,
           RegWrite_in, MemtoReg_in, Branch_in, Jump_in, MemRead_in, MemWrite_in
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage RV64 pipeline.
// Forwards operands from EX/MEM and MEM/WB, runs the ALU, resolves
// branches/jumps into a combinational PC redirect, and holds the EX/MEM
// pipeline register.
// Ports:
//   clk, reset (async, active-low)
//   idex            ID/EX bundle (ex_stage_if.slave)
//   stall           memory-stage stall, freezes EX/MEM and blocks redirect
//   wb_rd/wb_RegWrite/wb_data   MEM/WB writeback (forwarding source)
//   redirect_valid/redirect_pc  combinational PC redirect
//   alu_result_out, store_data_out, rd_out, func3_out, RegWrite_out,
//   MemtoReg_out, MemRead_out, MemWrite_out   EX/MEM register outputs
module ex_stage (
  input  logic              clk,
  input  logic              reset,
  ex_stage_if.slave         idex,
  input  logic              stall,
  input  logic [4:0]        wb_rd,
  input  logic              wb_RegWrite,
  input  logic [63:0]       wb_data,
  output logic              redirect_valid,
  output logic [63:0]       redirect_pc,
  output logic [63:0]       alu_result_out,
  output logic [63:0]       store_data_out,
  output logic [4:0]        rd_out,
  output logic [2:0]        func3_out,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic              MemRead_out,
  output logic              MemWrite_out
);

  logic [63:0] r_alu_result, r_store_data;
  logic [4:0]  r_rd;
  logic [2:0]  r_func3;
  logic        r_reg_write, r_mem_to_reg, r_mem_read, r_mem_write;

  logic [63:0] w_fwd_a, w_fwd_b, w_op_b;
  logic [63:0] w_a_ext, w_b_ext, w_srl_src, w_arith, w_raw, w_result;
  logic [5:0]  w_shamt;
  logic        w_cmp, w_taken;
  logic [63:0] w_target;
  logic        w_exm_fwd_ok;

  // A load sitting in EX/MEM has no data yet, so it is never a forward source.
  assign w_exm_fwd_ok = r_reg_write && !r_mem_to_reg && (r_rd != 5'd0);

  always_comb begin
    w_fwd_a = idex.rs1_data_in;
    if (w_exm_fwd_ok && (r_rd == idex.rs1_E_in))
      w_fwd_a = r_alu_result;
    else if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == idex.rs1_E_in))
      w_fwd_a = wb_data;

    w_fwd_b = idex.rs2_data_in;
    if (w_exm_fwd_ok && (r_rd == idex.rs2_E_in))
      w_fwd_b = r_alu_result;
    else if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == idex.rs2_E_in))
      w_fwd_b = wb_data;
  end

  assign w_op_b  = idex.ALUSrc_in ? idex.imm_in : w_fwd_b;
  assign w_shamt = idex.InstType_in ? {1'b0, w_op_b[4:0]} : w_op_b[5:0];

  // Word ops: sign-extending the low halves first makes every 64-bit op
  // produce the correct low 32 bits (including SLT/SLTU ordering); SRLW
  // alone needs zero-filled upper bits so nothing shifts in from above.
  assign w_a_ext   = idex.InstType_in ? {{32{w_fwd_a[31]}}, w_fwd_a[31:0]} : w_fwd_a;
  assign w_b_ext   = idex.InstType_in ? {{32{w_op_b[31]}}, w_op_b[31:0]} : w_op_b;
  assign w_srl_src = idex.InstType_in ? {32'd0, w_fwd_a[31:0]} : w_fwd_a;

  always_comb begin
    w_arith = 64'd0;
    case (idex.func3_in)
      3'b000: w_arith = (idex.func75_in && idex.op5_in) ? (w_a_ext - w_b_ext)
                                                         : (w_a_ext + w_b_ext);
      3'b001: w_arith = w_a_ext << w_shamt;
      3'b010: w_arith = {63'd0, $signed(w_a_ext) < $signed(w_b_ext)};
      3'b011: w_arith = {63'd0, w_a_ext < w_b_ext};
      3'b100: w_arith = w_a_ext ^ w_b_ext;
      3'b101: w_arith = idex.func75_in ? 64'($signed(w_a_ext) >>> w_shamt)
                                       : (w_srl_src >> w_shamt);
      3'b110: w_arith = w_a_ext | w_b_ext;
      3'b111: w_arith = w_a_ext & w_b_ext;
      default: w_arith = 64'd0;
    endcase
  end

  always_comb begin
    w_raw = 64'd0;
    case (idex.ALUop_in)
      3'b000: w_raw = w_fwd_a + w_op_b;
      3'b010: w_raw = w_arith;
      3'b011: w_raw = idex.imm_in;
      3'b100: w_raw = idex.pc_in + idex.imm_in;
      3'b101: w_raw = idex.pc_in + 64'd4;
      default: w_raw = 64'd0;
    endcase
  end

  assign w_result = (idex.InstType_in && ((idex.ALUop_in == 3'b000) || (idex.ALUop_in == 3'b010)))
                    ? {{32{w_raw[31]}}, w_raw[31:0]} : w_raw;

  always_comb begin
    w_cmp = 1'b0;
    case (idex.func3_in)
      3'b000: w_cmp = (w_fwd_a == w_op_b);
      3'b001: w_cmp = (w_fwd_a != w_op_b);
      3'b100: w_cmp = ($signed(w_fwd_a) <  $signed(w_op_b));
      3'b101: w_cmp = ($signed(w_fwd_a) >= $signed(w_op_b));
      3'b110: w_cmp = (w_fwd_a <  w_op_b);
      3'b111: w_cmp = (w_fwd_a >= w_op_b);
      default: w_cmp = 1'b0;
    endcase
  end

  assign w_taken = idex.Branch_in && (idex.ALUop_in == 3'b001) && w_cmp;

  // JALR adds to the forwarded rs1 and clears bit 0; JAL and branches are pc-relative.
  assign w_target = (idex.Jump_in && idex.ALUSrc_in)
                    ? ((w_fwd_a + idex.imm_in) & ~64'd1)
                    : (idex.pc_in + idex.imm_in);

  // Redirect is also held off during reset so nothing upstream flushes on garbage.
  assign redirect_valid = (w_taken || idex.Jump_in) && !stall && reset;
  assign redirect_pc    = redirect_valid ? w_target : 64'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alu_result <= 64'd0;
      r_store_data <= 64'd0;
      r_rd         <= 5'd0;
      r_func3      <= 3'd0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else if (!stall) begin
      r_alu_result <= w_result;
      r_store_data <= w_fwd_b;
      r_rd         <= idex.rd_in;
      r_func3      <= idex.func3_in;
      r_reg_write  <= idex.RegWrite_in;
      r_mem_to_reg <= idex.MemtoReg_in;
      r_mem_read   <= idex.MemRead_in;
      r_mem_write  <= idex.MemWrite_in;
    end
  end

  assign alu_result_out = r_alu_result;
  assign store_data_out = r_store_data;
  assign rd_out         = r_rd;
  assign func3_out      = r_func3;
  assign RegWrite_out   = r_reg_write;
  assign MemtoReg_out   = r_mem_to_reg;
  assign MemRead_out    = r_mem_read;
  assign MemWrite_out   = r_mem_write;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage. Expected EX/MEM contents are
// queued when an instruction is driven and popped after the capturing edge.
module tb_ex_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [4:0]  wb_rd;
  logic        wb_RegWrite;
  logic [63:0] wb_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] alu_result_out, store_data_out;
  logic [4:0]  rd_out;
  logic [2:0]  func3_out;
  logic        RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out;

  ex_stage_if u_if ();

  ex_stage u_dut (
    .clk            (clk),
    .reset          (reset),
    .idex           (u_if),
    .stall          (stall),
    .wb_rd          (wb_rd),
    .wb_RegWrite    (wb_RegWrite),
    .wb_data        (wb_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .alu_result_out (alu_result_out),
    .store_data_out (store_data_out),
    .rd_out         (rd_out),
    .func3_out      (func3_out),
    .RegWrite_out   (RegWrite_out),
    .MemtoReg_out   (MemtoReg_out),
    .MemRead_out    (MemRead_out),
    .MemWrite_out   (MemWrite_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  ctl;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    u_if.pc_in = 64'd0;       u_if.rs1_data_in = 64'd0; u_if.rs2_data_in = 64'd0;
    u_if.imm_in = 64'd0;      u_if.rs1_E_in = 5'd0;     u_if.rs2_E_in = 5'd0;
    u_if.rd_in = 5'd0;        u_if.func3_in = 3'd0;     u_if.func75_in = 1'b0;
    u_if.op5_in = 1'b0;       u_if.ALUop_in = 3'd0;     u_if.InstType_in = 1'b0;
    u_if.ALUSrc_in = 1'b0;    u_if.RegWrite_in = 1'b0;  u_if.MemtoReg_in = 1'b0;
    u_if.Branch_in = 1'b0;    u_if.Jump_in = 1'b0;      u_if.MemRead_in = 1'b0;
    u_if.MemWrite_in = 1'b0;
    wb_rd = 5'd0; wb_RegWrite = 1'b0; wb_data = 64'd0; stall = 1'b0;
  endtask

  task automatic set_rr(input logic [4:0] rs1, input logic [63:0] d1,
                        input logic [4:0] rs2, input logic [63:0] d2, input logic [4:0] rd);
    u_if.rs1_E_in = rs1; u_if.rs1_data_in = d1;
    u_if.rs2_E_in = rs2; u_if.rs2_data_in = d2;
    u_if.rd_in = rd;
  endtask

  task automatic set_alu(input logic [2:0] aop, input logic [2:0] f3,
                         input logic f75, input logic o5, input logic w);
    u_if.ALUop_in = aop; u_if.func3_in = f3; u_if.func75_in = f75;
    u_if.op5_in = o5;    u_if.InstType_in = w;
  endtask

  // Called just after a rising edge with inputs already driven: checks the
  // combinational redirect, queues the expected EX/MEM contents, clocks once
  // and compares against the popped entry.
  task automatic step(input string name, input logic [63:0] exp_res, input logic [63:0] exp_sd,
                      input logic exp_rv, input logic [63:0] exp_rpc);
    exp_t e, got;
    #3;
    check_eq({name, "_redir_v"}, {63'd0, redirect_valid}, {63'd0, exp_rv});
    check_eq({name, "_redir_pc"}, redirect_pc, exp_rpc);
    e.res = exp_res; e.sd = exp_sd; e.rd = u_if.rd_in; e.f3 = u_if.func3_in;
    e.ctl = {u_if.RegWrite_in, u_if.MemtoReg_in, u_if.MemRead_in, u_if.MemWrite_in};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard_empty observed=0 expected=1", name);
    end else begin
      got = sb_q.pop_front();
      last_exp = got;
      check_eq({name, "_res"}, alu_result_out, got.res);
      check_eq({name, "_sd"}, store_data_out, got.sd);
      check_eq({name, "_rd"}, {59'd0, rd_out}, {59'd0, got.rd});
      check_eq({name, "_f3"}, {61'd0, func3_out}, {61'd0, got.f3});
      check_eq({name, "_ctl"}, {60'd0, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out},
               {60'd0, got.ctl});
      $display("TXN %-10s res=%h sd=%h rd=%0d redir=%0b", name, alu_result_out,
               store_data_out, rd_out, exp_rv);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    check_eq({name, "_res"}, alu_result_out, 64'd0);
    check_eq({name, "_sd"}, store_data_out, 64'd0);
    check_eq({name, "_rdf3"}, {56'd0, rd_out, func3_out}, 64'd0);
    check_eq({name, "_ctl"}, {60'd0, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out}, 64'd0);
    check_eq({name, "_rv"}, {63'd0, redirect_valid}, 64'd0);
  endtask

  initial begin
    clear_inputs();
    // Reset with arbitrary, redirect-provoking inputs.
    reset = 1'b0;
    set_rr(5'd1, 64'h1234, 5'd2, 64'h5678, 5'd9);
    set_alu(3'b010, 3'b000, 1'b0, 1'b1, 1'b0);
    u_if.RegWrite_in = 1'b1; u_if.MemWrite_in = 1'b1; u_if.Jump_in = 1'b1;
    u_if.pc_in = 64'h80;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    $display("TXN reset      outputs held at zero");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // ADD 5 + 7
    clear_inputs();
    set_rr(5'd1, 64'd5, 5'd2, 64'd7, 5'd1);
    set_alu(3'b010, 3'b000, 1'b0, 1'b1, 1'b0);
    u_if.RegWrite_in = 1'b1;
    step("add", 64'd12, 64'd7, 1'b0, 64'd0);

    // x3 = 10 + 20
    set_rr(5'd10, 64'd10, 5'd11, 64'd20, 5'd3);
    step("add_x3", 64'd30, 64'd20, 1'b0, 64'd0);

    // Reads x3 twice; WB also writes x3=99 but EX/MEM must win.
    set_rr(5'd3, 64'd1000, 5'd3, 64'd2000, 5'd4);
    wb_rd = 5'd3; wb_RegWrite = 1'b1; wb_data = 64'd99;
    step("fwd_prio", 64'd60, 64'd30, 1'b0, 64'd0);

    // Only WB matches x3 now.
    set_rr(5'd3, 64'd1000, 5'd5, 64'd1, 5'd0);
    step("fwd_wb", 64'd100, 64'd1, 1'b0, 64'd0);

    // x0 reads never forward, even though EX/MEM and WB both name x0.
    set_rr(5'd0, 64'd7, 5'd6, 64'd1, 5'd7);
    wb_rd = 5'd0; wb_data = 64'd99;
    step("fwd_x0", 64'd8, 64'd1, 1'b0, 64'd0);

    // Load to x5 (address calc), then a consumer: load is not a forward source.
    set_rr(5'd12, 64'd100, 5'd13, 64'd0, 5'd5);
    set_alu(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    u_if.ALUSrc_in = 1'b1; u_if.imm_in = 64'd8;
    u_if.MemtoReg_in = 1'b1; u_if.MemRead_in = 1'b1; wb_RegWrite = 1'b0;
    step("load", 64'd108, 64'd0, 1'b0, 64'd0);

    clear_inputs();
    set_rr(5'd5, 64'd3, 5'd0, 64'd0, 5'd8);
    set_alu(3'b010, 3'b000, 1'b0, 1'b1, 1'b0);
    u_if.RegWrite_in = 1'b1;
    wb_rd = 5'd5; wb_RegWrite = 1'b1; wb_data = 64'd50;
    step("ld_use_wb", 64'd50, 64'd0, 1'b0, 64'd0);
    wb_RegWrite = 1'b0;

    // SUB 5 - 7
    set_rr(5'd14, 64'd5, 5'd15, 64'd7, 5'd9);
    set_alu(3'b010, 3'b000, 1'b1, 1'b1, 1'b0);
    step("sub", 64'hFFFF_FFFF_FFFF_FFFE, 64'd7, 1'b0, 64'd0);

    // ADDW overflow into sign bit
    set_rr(5'd14, 64'h7FFF_FFFF, 5'd15, 64'd1, 5'd10);
    set_alu(3'b010, 3'b000, 1'b0, 1'b1, 1'b1);
    step("addw", 64'hFFFF_FFFF_8000_0000, 64'd1, 1'b0, 64'd0);

    // SRAW 0x80000000 >> 4
    set_rr(5'd14, 64'h8000_0000, 5'd15, 64'd4, 5'd11);
    set_alu(3'b010, 3'b101, 1'b1, 1'b1, 1'b1);
    step("sraw", 64'hFFFF_FFFF_F800_0000, 64'd4, 1'b0, 64'd0);

    // BLT -1 < 1 (taken), then BLTU on the same operands (not taken)
    clear_inputs();
    set_rr(5'd16, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17, 64'd1, 5'd0);
    set_alu(3'b001, 3'b100, 1'b0, 1'b0, 1'b0);
    u_if.Branch_in = 1'b1; u_if.pc_in = 64'h100; u_if.imm_in = 64'h20;
    step("blt", 64'd0, 64'd1, 1'b1, 64'h120);
    u_if.func3_in = 3'b110;
    step("bltu", 64'd0, 64'd1, 1'b0, 64'd0);

    // JALR rs1=0x1001 imm=2, pc=0x40
    clear_inputs();
    set_rr(5'd18, 64'h1001, 5'd0, 64'd0, 5'd1);
    set_alu(3'b101, 3'b000, 1'b0, 1'b0, 1'b0);
    u_if.Jump_in = 1'b1; u_if.ALUSrc_in = 1'b1; u_if.RegWrite_in = 1'b1;
    u_if.pc_in = 64'h40; u_if.imm_in = 64'd2;
    step("jalr", 64'h44, 64'd0, 1'b1, 64'h1002);

    // JAL pc=0x40 imm=0x100
    u_if.ALUSrc_in = 1'b0; u_if.imm_in = 64'h100;
    step("jal", 64'h44, 64'd0, 1'b1, 64'h140);

    // Known value in EX/MEM, then stall with a taken BEQ waiting in EX.
    clear_inputs();
    set_rr(5'd20, 64'd70, 5'd21, 64'd7, 5'd12);
    set_alu(3'b010, 3'b000, 1'b0, 1'b1, 1'b0);
    u_if.RegWrite_in = 1'b1;
    step("pre_stall", 64'd77, 64'd7, 1'b0, 64'd0);

    clear_inputs();
    set_rr(5'd22, 64'd5, 5'd23, 64'd5, 5'd0);
    set_alu(3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
    u_if.Branch_in = 1'b1; u_if.pc_in = 64'h200; u_if.imm_in = 64'h10;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      check_eq("stall_rv", {63'd0, redirect_valid}, 64'd0);
      check_eq("stall_rpc", redirect_pc, 64'd0);
      @(posedge clk);
      #1;
      check_eq("stall_res", alu_result_out, last_exp.res);
      check_eq("stall_rd", {59'd0, rd_out}, {59'd0, last_exp.rd});
      check_eq("stall_ctl", {63'd0, RegWrite_out}, {63'd0, last_exp.ctl[3]});
      $display("TXN stall%0d     res=%h held", i, alu_result_out);
    end
    stall = 1'b0;
    step("beq_release", 64'd0, 64'd5, 1'b1, 64'h210);
    clear_inputs();
    step("nop", 64'd0, 64'd0, 1'b0, 64'd0);

    // Mid-stream asynchronous reset, then capture resumes on the next edge.
    set_rr(5'd24, 64'd1, 5'd25, 64'd2, 5'd13);
    set_alu(3'b010, 3'b000, 1'b0, 1'b1, 1'b0);
    u_if.RegWrite_in = 1'b1;
    step("pre_rst", 64'd3, 64'd2, 1'b0, 64'd0);
    reset = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    $display("TXN async_rst  outputs cleared");
    #1;
    reset = 1'b1;
    set_rr(5'd24, 64'd40, 5'd25, 64'd2, 5'd14);
    step("post_rst", 64'd42, 64'd2, 1'b0, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
